instruction_fetch: RTL

- Sits between `program_counter` and the decoder.
- Takes the current `pc` and fetches one instruction of `INST_W_BYTES` bytes from the byte-wide instruction memory, one byte per memory handshake, low byte first.
- Assembles the bytes into an instruction word and presents it to the decoder with a valid/ready handshake.
- Drives `busy`, which the top level uses to hold the PC while a fetch is in flight.

---
 rtl/instruction_fetch_if.sv | 35 +++
 rtl/instruction_fetch.sv | 112 +++++++++++
 2 files changed

// File: rtl/instruction_fetch_if.sv
// Memory-side and decoder-side handshake bundle for instruction_fetch.
// master = fetch unit; slave = memory/decoder side.
interface instruction_fetch_if #(
  parameter int I_ADDR_W     = 12,
  parameter int INST_W_BYTES = 2,
  parameter int MEM_DATA_W   = 8
);
  logic                        mem_req;
  logic [I_ADDR_W-1:0]         mem_addr;
  logic [MEM_DATA_W-1:0]       mem_rdata;
  logic                        mem_rvalid;
  logic [INST_W_BYTES*8-1:0]   inst;
  logic                        inst_valid;
  logic                        inst_ready;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_rdata,
    input  mem_rvalid,
    output inst,
    output inst_valid,
    input  inst_ready
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_rdata,
    output mem_rvalid,
    input  inst,
    input  inst_valid,
    output inst_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// Byte-serial instruction fetch: reads INST_W_BYTES bytes little-endian from
// byte-wide memory and hands the assembled word to the decoder.
module instruction_fetch #(
  parameter int I_ADDR_W     = 12,
  parameter int INST_W_BYTES = 2,
  parameter int MEM_DATA_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [I_ADDR_W-1:0] pc,
  input  logic                fetch_start,
  input  logic                flush,
  output logic                busy,
  instruction_fetch_if.master fif
);

  localparam int INST_W = INST_W_BYTES * 8;
  localparam int CNT_W  = (INST_W_BYTES > 1) ? $clog2(INST_W_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(INST_W_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [I_ADDR_W-1:0] base_q, base_nxt;
  logic [CNT_W-1:0]    cnt_q, cnt_nxt;
  logic [INST_W-1:0]   asm_q, asm_nxt;
  logic [INST_W-1:0]   inst_q, inst_nxt;
  logic [INST_W-1:0]   merged;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Bytes assemble in asm_q; inst_q only changes on a completed word, so a
  // flushed partial fetch never disturbs the last delivered instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q <= '0;
      cnt_q  <= '0;
      asm_q  <= '0;
      inst_q <= '0;
    end else begin
      base_q <= base_nxt;
      cnt_q  <= cnt_nxt;
      asm_q  <= asm_nxt;
      inst_q <= inst_nxt;
    end
  end

  always_comb begin
    merged = asm_q;
    merged[int'(cnt_q)*MEM_DATA_W +: MEM_DATA_W] = fif.mem_rdata;
  end

  always_comb begin
    state_nxt = state;
    base_nxt  = base_q;
    cnt_nxt   = cnt_q;
    asm_nxt   = asm_q;
    inst_nxt  = inst_q;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (fetch_start) begin
            state_nxt = FETCH;
            base_nxt  = pc;
            cnt_nxt   = '0;
          end
        end
        FETCH: begin
          if (fif.mem_rvalid) begin
            asm_nxt = merged;
            if (cnt_q == LAST_BYTE) begin
              inst_nxt  = merged;
              state_nxt = HOLD;
            end else begin
              cnt_nxt = cnt_q + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (fif.inst_ready) begin
            if (fetch_start) begin
              state_nxt = FETCH;
              base_nxt  = pc;
              cnt_nxt   = '0;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    fif.mem_req    = (state == FETCH);
    fif.mem_addr   = base_q + I_ADDR_W'(cnt_q);
    fif.inst       = inst_q;
    fif.inst_valid = (state == HOLD);
    busy           = (state == FETCH) || ((state == HOLD) && !fif.inst_ready);
  end

endmodule
